// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life controller slice.
// Holds the controller state encoding and the default parameter values
// used by life_ctrl_fsm.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RAND,
        RUN,
        PAUSE,
        STEP,
        DONE
    } life_state_e;

    localparam int unsigned DEF_ROWS        = 16;
    localparam int unsigned DEF_RAND_CYCLES = 64;
    localparam int unsigned DEF_BASE_DIV    = 4;
    localparam int unsigned DEF_SPD_W       = 2;
    localparam int unsigned DEF_DIV_W       = 16;
    localparam int unsigned DEF_GEN_W       = 16;
    localparam int unsigned DEF_MAX_GENS    = 0;

endpackage

// File: rtl/life_ctrl_fsm_tick_divider.sv
// Free-running rate counter for the RUN state.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear_i        force the count to zero (held while not running)
//   enable_i       count this cycle
//   period_i       tick period in cycles (>= 1)
//   tick_o         high in the cycle the count reaches period_i-1
// The compare is >= so that shrinking period_i mid-count ticks at once
// instead of wrapping the whole counter range.
module tick_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q >= (period_i - DIV_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/life_ctrl_fsm.sv
// Top-level sequencing controller for the Game-of-Life grid.
// Sequences grid clear, LFSR fill, free-run, pause, single-step and an
// optional generation limit.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clear_req           level: wipe the grid one row per cycle
//   randomize           level: fill the grid from the LFSR
//   start, pause        level: run / hold evolution
//   step                single step on each rising edge while paused
//   speed_sel           run period = BASE_DIV << speed_sel
//   clr_en, clr_row     row clear strobe and row address
//   rnd_en              shift LFSR into grid
//   gen_en              one-cycle advance-generation strobe
//   gen_count           generations since last clear/randomize (saturating)
//   running, done       state flags
//
// state | meaning
// IDLE  | waiting for clear, randomize or start
// CLEAR | wiping rows 0..ROWS-1, one per cycle, not interruptible
// RAND  | rnd_en held for RAND_CYCLES cycles, then PAUSE
// RUN   | free-run, gen_en once per period
// PAUSE | hold; start resumes, step edge single-steps
// STEP  | one gen_en, then back to PAUSE
// DONE  | generation limit reached; only clear/randomize leave
module life_ctrl_fsm
    import life_pkg::*;
#(
    parameter int unsigned ROWS        = DEF_ROWS,
    parameter int unsigned RAND_CYCLES = DEF_RAND_CYCLES,
    parameter int unsigned BASE_DIV    = DEF_BASE_DIV,
    parameter int unsigned SPD_W       = DEF_SPD_W,
    parameter int unsigned DIV_W       = DEF_DIV_W,
    parameter int unsigned GEN_W       = DEF_GEN_W,
    parameter int unsigned MAX_GENS    = DEF_MAX_GENS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear_req,
    input  logic                    randomize,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    step,
    input  logic [SPD_W-1:0]        speed_sel,
    output logic                    clr_en,
    output logic [$clog2(ROWS)-1:0] clr_row,
    output logic                    rnd_en,
    output logic                    gen_en,
    output logic [GEN_W-1:0]        gen_count,
    output logic                    running,
    output logic                    done
);

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned RND_W = $clog2(RAND_CYCLES) + 1;
    localparam int unsigned GW1   = GEN_W + 1;

    life_state_e      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [SPD_W-1:0] spd_q;
    logic             step_q;
    logic [DIV_W-1:0] period;
    logic             tick, gen_fire, limit_hit, step_rise, row_last, rnd_last;
    logic             go_clear, go_rand;

    // speed_sel is registered so gen_en depends only on flops.
    assign period = DIV_W'(BASE_DIV) << spd_q;

    tick_divider #(.DIV_W(DIV_W)) u_tick_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (state_q != RUN),
        .enable_i (state_q == RUN),
        .period_i (period),
        .tick_o   (tick)
    );

    assign gen_fire  = (state_q == STEP) || tick;
    assign limit_hit = (MAX_GENS != 0) && gen_fire &&
                       (({1'b0, gen_q} + GW1'(1)) == GW1'(MAX_GENS));
    assign step_rise = step && !step_q;
    assign row_last  = (row_q == ROW_W'(ROWS - 1));
    assign rnd_last  = (rnd_q == RND_W'(RAND_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_req)           state_d = CLEAR;
                else if (randomize)      state_d = RAND;
                else if (start && !pause) state_d = RUN;
            end
            CLEAR: begin
                if (row_last) state_d = IDLE;
            end
            RAND: begin
                if (clear_req)     state_d = CLEAR;
                else if (rnd_last) state_d = PAUSE;
            end
            RUN: begin
                if (clear_req)      state_d = CLEAR;
                else if (randomize) state_d = RAND;
                else if (limit_hit) state_d = DONE;
                else if (pause)     state_d = PAUSE;
            end
            PAUSE: begin
                if (clear_req)            state_d = CLEAR;
                else if (randomize)       state_d = RAND;
                else if (start && !pause) state_d = RUN;
                else if (step_rise)       state_d = STEP;
            end
            STEP: begin
                if (clear_req)      state_d = CLEAR;
                else if (randomize) state_d = RAND;
                else if (limit_hit) state_d = DONE;
                else                state_d = PAUSE;
            end
            DONE: begin
                if (clear_req)      state_d = CLEAR;
                else if (randomize) state_d = RAND;
            end
            default: state_d = IDLE;
        endcase
    end

    assign go_clear = (state_d == CLEAR) && (state_q != CLEAR);
    assign go_rand  = (state_d == RAND) && (state_q != RAND);

    always_comb begin
        row_d = ((state_q == CLEAR) && (state_d == CLEAR)) ? row_q + ROW_W'(1) : '0;
        rnd_d = ((state_q == RAND) && (state_d == RAND)) ? rnd_q + RND_W'(1) : '0;
        gen_d = gen_q;
        if (go_clear || go_rand) begin
            gen_d = '0;
        end else if (gen_fire && (gen_q != '1)) begin
            gen_d = gen_q + GEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            rnd_q   <= '0;
            gen_q   <= '0;
            spd_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rnd_q   <= rnd_d;
            gen_q   <= gen_d;
            spd_q   <= speed_sel;
            step_q  <= step;
        end
    end

    assign clr_en    = (state_q == CLEAR);
    assign clr_row   = row_q;
    assign rnd_en    = (state_q == RAND);
    assign gen_en    = gen_fire;
    assign gen_count = gen_q;
    assign running   = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule
